// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: circular buffer with registered read port,
// level threshold interrupt, character-timeout interrupt and sticky overflow flag.
module uart_rx_fifo #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned TIMEOUT_CLKS = 1000
) (
   input  logic                       in_Clk,
   input  logic                       in_Reset,
   input  logic                       in_RX_DV,
   input  logic [7:0]                 in_RX_Byte,
   input  logic                       in_Rd_En,
   output logic [7:0]                 out_Rd_Data,
   output logic                       out_Rd_Valid,
   output logic                       out_Empty,
   output logic                       out_Full,
   output logic [$clog2(DEPTH):0]     out_Count,
   input  logic [$clog2(DEPTH):0]     in_Threshold,
   output logic                       out_Thresh_IRQ,
   output logic                       out_Timeout_IRQ,
   output logic                       out_Overflow,
   input  logic                       in_Clr_Overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [1:0] T_IDLE    = 2'd0;
   localparam logic [1:0] T_COUNT   = 2'd1;
   localparam logic [1:0] T_EXPIRED = 2'd2;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    rd_data_q;
   logic          rd_valid_q;
   logic          ovf_q;
   logic [1:0]    t_state_q, t_state_d;
   logic [TW-1:0] tmr_q, tmr_d;

   logic rd_acc, wr_acc, drop, any_acc;

   assign rd_acc  = in_Rd_En && (count_q != '0);
   // A full FIFO still takes a byte when a read frees a slot in the same cycle.
   assign wr_acc  = in_RX_DV && ((count_q != CW'(DEPTH)) || rd_acc);
   assign drop    = in_RX_DV && !wr_acc;
   assign any_acc = wr_acc || rd_acc;

   always_comb begin
      count_d = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      t_state_d = t_state_q;
      tmr_d     = tmr_q;
      case (t_state_q)
         T_IDLE: begin
            tmr_d = '0;
            // Stay idle if the only byte is drained in this very cycle.
            if (count_q != '0 && count_d != '0) t_state_d = T_COUNT;
         end
         T_COUNT: begin
            if (count_d == '0) begin
               t_state_d = T_IDLE;
               tmr_d     = '0;
            end else if (any_acc) begin
               tmr_d = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
               if (tmr_q + TW'(1) == TW'(TIMEOUT_CLKS - 1)) t_state_d = T_EXPIRED;
            end
         end
         T_EXPIRED: begin
            if (any_acc) begin
               tmr_d     = '0;
               t_state_d = (count_d == '0) ? T_IDLE : T_COUNT;
            end
         end
         default: begin
            t_state_d = T_IDLE;
            tmr_d     = '0;
         end
      endcase
   end

   always_ff @(posedge in_Clk) begin
      if (in_Reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         t_state_q  <= T_IDLE;
         tmr_q      <= '0;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_acc) begin
            rd_ptr_q  <= rd_ptr_q + AW'(1);
            rd_data_q <= mem[rd_ptr_q];
         end
         rd_valid_q <= rd_acc;
         count_q    <= count_d;
         if (drop) ovf_q <= 1'b1;
         else if (in_Clr_Overflow) ovf_q <= 1'b0;
         t_state_q <= t_state_d;
         tmr_q     <= tmr_d;
      end
   end

   always_ff @(posedge in_Clk) begin
      if (!in_Reset && wr_acc) mem[wr_ptr_q] <= in_RX_Byte;
   end

   assign out_Rd_Data     = rd_data_q;
   assign out_Rd_Valid    = rd_valid_q;
   assign out_Count       = count_q;
   assign out_Empty       = (count_q == '0);
   assign out_Full        = (count_q == CW'(DEPTH));
   assign out_Thresh_IRQ  = (in_Threshold != '0) && (count_q >= in_Threshold);
   assign out_Timeout_IRQ = (t_state_q == T_EXPIRED);
   assign out_Overflow    = ovf_q;

endmodule
